// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen
//
// Trigger-driven single pulse generator. A rising edge on trigger_i starts one
// pulse of programmable length on data_o. The pulse can be active-high,
// active-low or a level toggle. While a pulse is running, the block ignores
// further triggers and any change to width_i or to a non-disabled pulse type.
//
// Ports
//   clk_i         system clock; all state updates occur on its rising edge
//   rstn_i        asynchronous active-low reset
//   pulse_type_i  00 disabled, 01 high pulse, 10 low pulse, 11 toggle
//   width_i       width code; decodes to a load value L, and the pulse
//                 lasts L+1 cycles
//   int_en_i      enables the done_int_o completion pulse
//   trigger_i     synchronous trigger; only its rising edge is used
//   data_o        generated waveform (registered)
//   busy_o        high while a pulse is in progress (registered)
//   done_int_o    one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module pulse_gen (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] pulse_type_i,
    input  logic [3:0] width_i,
    input  logic       int_en_i,
    input  logic       trigger_i,
    output logic       data_o,
    output logic       busy_o,
    output logic       done_int_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PT_OFF    = 2'b00,
        PT_HIGH   = 2'b01,
        PT_LOW    = 2'b10,
        PT_TOGGLE = 2'b11
    } pulse_type_e;

    // Width code to counter load value. The table is not a simple power of
    // two, so it is spelled out explicitly.
    function automatic logic [10:0] decode_width(input logic [3:0] code);
        logic [10:0] load;
        unique case (code)
            4'd0:    load = 11'd3;
            4'd1:    load = 11'd7;
            4'd2:    load = 11'd15;
            4'd3:    load = 11'd31;
            4'd4:    load = 11'd47;
            4'd5:    load = 11'd63;
            4'd6:    load = 11'd127;
            4'd7:    load = 11'd255;
            4'd8:    load = 11'd511;
            4'd9:    load = 11'd639;
            4'd10:   load = 11'd767;
            4'd11:   load = 11'd895;
            4'd12:   load = 11'd1023;
            4'd13:   load = 11'd1279;
            4'd14:   load = 11'd1535;
            default: load = 11'd2047;
        endcase
        return load;
    endfunction

    // Level driven while a pulse runs. Toggle inverts whatever level data_o
    // held before the trigger.
    function automatic logic active_level(input pulse_type_e ty, input logic cur);
        logic lvl;
        unique case (ty)
            PT_HIGH:   lvl = 1'b1;
            PT_LOW:    lvl = 1'b0;
            PT_TOGGLE: lvl = ~cur;
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    // Level driven outside a pulse. Toggle keeps the level it last produced.
    function automatic logic idle_level(input pulse_type_e ty, input logic cur);
        logic lvl;
        unique case (ty)
            PT_HIGH:   lvl = 1'b0;
            PT_LOW:    lvl = 1'b1;
            PT_TOGGLE: lvl = cur;
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    state_e      state_q, state_d;
    pulse_type_e type_q, type_d;
    pulse_type_e cur_type;
    logic [10:0] cnt_q, cnt_d;
    logic        trig_del_q;
    logic        trig_edge;
    logic        data_d;
    logic        done_d;

    assign cur_type  = pulse_type_e'(pulse_type_i);
    assign trig_edge = trigger_i & ~trig_del_q;

    // busy_o is taken straight from the state flop, so it is registered and
    // always agrees with the FSM.
    assign busy_o = (state_q == ST_ACTIVE);

    // The counter holds the latched load value, so no separate copy of L is
    // kept. The pulse type must be latched because the exit level depends on
    // it after pulse_type_i is allowed to change.
    always_comb begin
        // NOTE: every signal gets a default before the branches; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        data_d  = data_o;
        done_d  = 1'b0;

        if (cur_type == PT_OFF) begin
            // Disable wins in every state: abort silently with no completion.
            state_d = ST_IDLE;
            cnt_d   = '0;
            data_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trig_edge) begin
                        state_d = ST_ACTIVE;
                        type_d  = cur_type;
                        cnt_d   = decode_width(width_i);
                        data_d  = active_level(cur_type, data_o);
                    end else begin
                        data_d  = idle_level(cur_type, data_o);
                    end
                end
                ST_ACTIVE: begin
                    // Triggers and input changes are ignored here; only the
                    // latched type and the counter matter.
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - 11'd1;
                    end else begin
                        state_d = ST_IDLE;
                        data_d  = idle_level(type_q, data_o);
                        done_d  = int_en_i;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            type_q     <= PT_OFF;
            cnt_q      <= '0;
            trig_del_q <= 1'b0;
            data_o     <= 1'b0;
            done_int_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            cnt_q      <= cnt_d;
            trig_del_q <= trigger_i;
            data_o     <= data_d;
            done_int_o <= done_d;
        end
    end

endmodule
